// File: rtl/ap_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ap_mon_pkg                                                            |
// | Shared state encoding, default sizes and saturating increment helper. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ap_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUSY      = 2'd1,
      ST_WAIT_CONT = 2'd2
   } ap_state_e;

   localparam int unsigned c_def_num_ch = 2;
   localparam int unsigned c_def_cnt_w  = 32;
   localparam int unsigned c_sat_w      = 64;

   function automatic logic [c_sat_w-1:0] sat_inc(input logic [c_sat_w-1:0] v,
                                                  input logic [c_sat_w-1:0] maxv);
      return (v >= maxv) ? maxv : v + 64'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ap_chan_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ap_chan_tracker                                                       |
// | One ap_ctrl channel: handshake FSM, saturating counters, latencies.   |
// | Optional max latency tracking: AP_STATUS_MONITOR_MAXLAT_EN            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ap_chan_tracker
   import ap_mon_pkg::*;
#(
   parameter int unsigned CNT_W = c_def_cnt_w
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             ready_i,
   input  logic             done_i,
   input  logic             cont_i,
   input  logic             finish_i,
   input  logic             clear_i,
   output ap_state_e        state_o,
   output logic [CNT_W-1:0] start_cnt_o,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] last_lat_o,
   output logic [CNT_W-1:0] max_lat_o,
   output logic             ovf_o
);

   localparam logic [CNT_W-1:0]   c_max     = '1;
   localparam logic [c_sat_w-1:0] c_max_ext = c_sat_w'(c_max);

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
      return CNT_W'(sat_inc(c_sat_w'(v), c_max_ext));
   endfunction

   ap_state_e        state_q, state_d;
   logic [CNT_W-1:0] start_q, start_d;
   logic [CNT_W-1:0] done_q, done_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] lat_q, lat_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      done_d  = done_q;
      stall_d = stall_q;
      lat_d   = lat_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      if (clear_i) begin
         state_d = ST_IDLE;
         start_d = '0;
         done_d  = '0;
         stall_d = '0;
         lat_d   = '0;
         last_d  = '0;
         ovf_d   = 1'b0;
      end else if (!finish_i) begin
         // A done held without continue is a stall cycle, including the done cycle itself
         case (state_q)
            ST_IDLE: begin
               if (start_i && ready_i) begin
                  start_d = inc(start_q);
                  if (done_i) begin
                     last_d = CNT_W'(1);
                     if (cont_i) begin
                        done_d = inc(done_q);
                     end else begin
                        state_d = ST_WAIT_CONT;
                        stall_d = inc(stall_q);
                     end
                  end else begin
                     state_d = ST_BUSY;
                     lat_d   = CNT_W'(1);
                  end
               end
            end
            ST_BUSY: begin
               if (done_i) begin
                  last_d = inc(lat_q);
                  if (cont_i) begin
                     done_d  = inc(done_q);
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_WAIT_CONT;
                     stall_d = inc(stall_q);
                  end
               end else begin
                  lat_d = inc(lat_q);
               end
            end
            ST_WAIT_CONT: begin
               if (cont_i) begin
                  done_d  = inc(done_q);
                  state_d = ST_IDLE;
               end else begin
                  stall_d = inc(stall_q);
               end
            end
            default: state_d = ST_IDLE;
         endcase
         ovf_d = ovf_q | (start_d == c_max) | (done_d == c_max) | (stall_d == c_max);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         start_q <= '0;
         done_q  <= '0;
         stall_q <= '0;
         lat_q   <= '0;
         last_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         done_q  <= done_d;
         stall_q <= stall_d;
         lat_q   <= lat_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef AP_STATUS_MONITOR_MAXLAT_EN
   // max never falls below last, so comparing against last_d is enough
   logic [CNT_W-1:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (clear_i) begin
         max_d = '0;
      end else if (!finish_i && (last_d > max_q)) begin
         max_d = last_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_lat_o = max_q;
`else
   assign max_lat_o = '0;
`endif

   assign state_o     = state_q;
   assign start_cnt_o = start_q;
   assign done_cnt_o  = done_q;
   assign stall_cnt_o = stall_q;
   assign last_lat_o  = last_q;
   assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: rtl/ap_status_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ap_status_monitor                                                     |
// | NUM_CH ap_ctrl channel trackers with a registered per-channel readout.|
// | Optional max latency tracking: AP_STATUS_MONITOR_MAXLAT_EN            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module ap_status_monitor
   import ap_mon_pkg::*;
#(
   parameter  int unsigned NUM_CH = c_def_num_ch,
   parameter  int unsigned CNT_W  = c_def_cnt_w,
   localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NUM_CH-1:0] ap_start_i,
   input  logic [NUM_CH-1:0] ap_ready_i,
   input  logic [NUM_CH-1:0] ap_done_i,
   input  logic [NUM_CH-1:0] ap_continue_i,
   input  logic              finish_i,
   input  logic              clear_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic [CNT_W-1:0]  rd_start_cnt_o,
   output logic [CNT_W-1:0]  rd_done_cnt_o,
   output logic [CNT_W-1:0]  rd_stall_cnt_o,
   output logic [CNT_W-1:0]  rd_last_lat_o,
   output logic [CNT_W-1:0]  rd_max_lat_o,
   output logic [1:0]        rd_state_o,
   output logic              rd_ovf_o
);

   ap_state_e         ch_state [NUM_CH];
   logic [CNT_W-1:0]  ch_start [NUM_CH];
   logic [CNT_W-1:0]  ch_done  [NUM_CH];
   logic [CNT_W-1:0]  ch_stall [NUM_CH];
   logic [CNT_W-1:0]  ch_last  [NUM_CH];
   logic [CNT_W-1:0]  ch_max   [NUM_CH];
   logic [NUM_CH-1:0] ch_ovf;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         ap_chan_tracker #(
            .CNT_W (CNT_W)
         ) u_trk (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .start_i     (ap_start_i[g]),
            .ready_i     (ap_ready_i[g]),
            .done_i      (ap_done_i[g]),
            .cont_i      (ap_continue_i[g]),
            .finish_i    (finish_i),
            .clear_i     (clear_i),
            .state_o     (ch_state[g]),
            .start_cnt_o (ch_start[g]),
            .done_cnt_o  (ch_done[g]),
            .stall_cnt_o (ch_stall[g]),
            .last_lat_o  (ch_last[g]),
            .max_lat_o   (ch_max[g]),
            .ovf_o       (ch_ovf[g])
         );
      end
   endgenerate

   ap_state_e        rd_state_q, rd_state_d;
   logic [CNT_W-1:0] rd_start_q, rd_start_d;
   logic [CNT_W-1:0] rd_done_q, rd_done_d;
   logic [CNT_W-1:0] rd_stall_q, rd_stall_d;
   logic [CNT_W-1:0] rd_last_q, rd_last_d;
   logic [CNT_W-1:0] rd_max_q, rd_max_d;
   logic             rd_ovf_q, rd_ovf_d;

   // An unmatched select (out of range) leaves every field at zero
   always_comb begin
      rd_state_d = ST_IDLE;
      rd_start_d = '0;
      rd_done_d  = '0;
      rd_stall_d = '0;
      rd_last_d  = '0;
      rd_max_d   = '0;
      rd_ovf_d   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (rd_sel_i == SEL_W'(i)) begin
            rd_state_d = ch_state[i];
            rd_start_d = ch_start[i];
            rd_done_d  = ch_done[i];
            rd_stall_d = ch_stall[i];
            rd_last_d  = ch_last[i];
            rd_max_d   = ch_max[i];
            rd_ovf_d   = ch_ovf[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_state_q <= ST_IDLE;
         rd_start_q <= '0;
         rd_done_q  <= '0;
         rd_stall_q <= '0;
         rd_last_q  <= '0;
         rd_max_q   <= '0;
         rd_ovf_q   <= 1'b0;
      end else if (clear_i) begin
         rd_state_q <= ST_IDLE;
         rd_start_q <= '0;
         rd_done_q  <= '0;
         rd_stall_q <= '0;
         rd_last_q  <= '0;
         rd_max_q   <= '0;
         rd_ovf_q   <= 1'b0;
      end else if (!finish_i) begin
         rd_state_q <= rd_state_d;
         rd_start_q <= rd_start_d;
         rd_done_q  <= rd_done_d;
         rd_stall_q <= rd_stall_d;
         rd_last_q  <= rd_last_d;
         rd_max_q   <= rd_max_d;
         rd_ovf_q   <= rd_ovf_d;
      end
   end

   assign rd_state_o     = rd_state_q;
   assign rd_start_cnt_o = rd_start_q;
   assign rd_done_cnt_o  = rd_done_q;
   assign rd_stall_cnt_o = rd_stall_q;
   assign rd_last_lat_o  = rd_last_q;
   assign rd_max_lat_o   = rd_max_q;
   assign rd_ovf_o       = rd_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_status_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ap_status_monitor                                                  |
// | Directed and random stimulus against a transaction-level model.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_ap_status_monitor;

   localparam int NCH  = 2;
   localparam int CW   = 8;
   localparam int MAXV = 255;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b1;
   logic [NCH-1:0] start  = '0;
   logic [NCH-1:0] ready  = '0;
   logic [NCH-1:0] done   = '0;
   logic [NCH-1:0] cont   = '1;
   logic           finish = 1'b0;
   logic           clear  = 1'b0;
   logic           rd_sel = 1'b0;
   logic [1:0]     sel3   = 2'd3;

   logic [CW-1:0] o_start, o_done, o_stall, o_last, o_max;
   logic [1:0]    o_state;
   logic          o_ovf;
   logic [CW-1:0] p_start, p_done, p_stall, p_last, p_max;
   logic [1:0]    p_state;
   logic          p_ovf;

   always #5 clk = ~clk;

   ap_status_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
      .clk_i (clk), .rst_ni (rst_n),
      .ap_start_i (start), .ap_ready_i (ready), .ap_done_i (done), .ap_continue_i (cont),
      .finish_i (finish), .clear_i (clear), .rd_sel_i (rd_sel),
      .rd_start_cnt_o (o_start), .rd_done_cnt_o (o_done), .rd_stall_cnt_o (o_stall),
      .rd_last_lat_o (o_last), .rd_max_lat_o (o_max), .rd_state_o (o_state), .rd_ovf_o (o_ovf)
   );

   // Three-channel instance: a 2-bit select can address the out-of-range value 3
   ap_status_monitor #(.NUM_CH(3), .CNT_W(CW)) dut3 (
      .clk_i (clk), .rst_ni (rst_n),
      .ap_start_i ({1'b0, start}), .ap_ready_i ({1'b0, ready}),
      .ap_done_i ({1'b0, done}), .ap_continue_i ({1'b1, cont}),
      .finish_i (finish), .clear_i (clear), .rd_sel_i (sel3),
      .rd_start_cnt_o (p_start), .rd_done_cnt_o (p_done), .rd_stall_cnt_o (p_stall),
      .rd_last_lat_o (p_last), .rd_max_lat_o (p_max), .rd_state_o (p_state), .rd_ovf_o (p_ovf)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int live   = 0;

   // Transaction-level model per channel
   int m_start [NCH];
   int m_done  [NCH];
   int m_stall [NCH];
   int m_last  [NCH];
   int m_max   [NCH];
   int m_t0    [NCH];
   bit m_active[NCH];
   bit m_held  [NCH];
   bit m_ovf   [NCH];
   int e_start, e_done, e_stall, e_last, e_max, e_state;
   bit e_ovf;

   function automatic int sat(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      e_start = 0; e_done = 0; e_stall = 0; e_last = 0; e_max = 0; e_state = 0; e_ovf = 0;
      for (int c = 0; c < NCH; c++) begin
         m_start[c] = 0; m_done[c] = 0; m_stall[c] = 0; m_last[c] = 0; m_max[c] = 0;
         m_t0[c] = 0; m_active[c] = 0; m_held[c] = 0; m_ovf[c] = 0;
      end
   endtask

   task automatic end_txn(input int c, input int lat);
      m_active[c] = 0;
      m_last[c]   = sat(lat);
      if (m_last[c] > m_max[c]) m_max[c] = m_last[c];
      if (cont[c]) begin
         m_done[c] = sat(m_done[c] + 1);
      end else begin
         m_held[c]  = 1;
         m_stall[c] = sat(m_stall[c] + 1);
      end
   endtask

   task automatic model_edge();
      if (clear) begin
         model_reset();
      end else if (!finish) begin
         e_start = m_start[rd_sel];
         e_done  = m_done[rd_sel];
         e_stall = m_stall[rd_sel];
         e_last  = m_last[rd_sel];
`ifdef AP_STATUS_MONITOR_MAXLAT_EN
         e_max   = m_max[rd_sel];
`else
         e_max   = 0;
`endif
         e_state = m_held[rd_sel] ? 2 : (m_active[rd_sel] ? 1 : 0);
         e_ovf   = m_ovf[rd_sel];
         for (int c = 0; c < NCH; c++) begin
            if (m_held[c]) begin
               if (cont[c]) begin
                  m_done[c] = sat(m_done[c] + 1);
                  m_held[c] = 0;
               end else begin
                  m_stall[c] = sat(m_stall[c] + 1);
               end
            end else if (m_active[c]) begin
               if (done[c]) end_txn(c, live - m_t0[c] + 1);
            end else if (start[c] && ready[c]) begin
               m_start[c] = sat(m_start[c] + 1);
               if (done[c]) end_txn(c, 1);
               else begin
                  m_active[c] = 1;
                  m_t0[c]     = live;
               end
            end
            if (m_start[c] == MAXV || m_done[c] == MAXV || m_stall[c] == MAXV) m_ovf[c] = 1;
         end
         live++;
      end
   endtask

   task automatic check_all();
      chk("rd_start_cnt", 64'(o_start), 64'(e_start));
      chk("rd_done_cnt",  64'(o_done),  64'(e_done));
      chk("rd_stall_cnt", 64'(o_stall), 64'(e_stall));
      chk("rd_last_lat",  64'(o_last),  64'(e_last));
      chk("rd_max_lat",   64'(o_max),   64'(e_max));
      chk("rd_state",     64'(o_state), 64'(e_state));
      chk("rd_ovf",       64'(o_ovf),   64'(e_ovf));
      chk("oob_sel_zero", 64'({p_start | p_done | p_stall | p_last | p_max, p_state, p_ovf}), 64'd0);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic txn(input int c, input int lat);
      start[c] = 1; ready[c] = 1;
      if (lat == 1) begin done[c] = 1; cont[c] = 1; end
      tick();
      start[c] = 0; ready[c] = 0; done[c] = 0;
      if (lat > 1) begin
         repeat (lat - 2) tick();
         done[c] = 1; cont[c] = 1;
         tick();
         done[c] = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_all();
      rst_n = 1'b1;

      // single transaction on ch0: start at 5, done+continue at 9
      idle_until(5);
      start[0] = 1; ready[0] = 1;
      tick();
      start[0] = 0; ready[0] = 0;
      idle_until(9);
      done[0] = 1;
      tick();
      done[0] = 0;
      tick();
      chk("single_start", 64'(o_start), 64'd1);
      chk("single_done",  64'(o_done),  64'd1);
      chk("single_lat",   64'(o_last),  64'd5);
      chk("single_state", 64'(o_state), 64'd0);

      // continue stall on ch1: done at 20, continue low for 3 cycles
      rd_sel = 1'b1;
      idle_until(16);
      start[1] = 1; ready[1] = 1;
      tick();
      start[1] = 0; ready[1] = 0;
      idle_until(20);
      done[1] = 1; cont[1] = 0;
      tick();
      done[1] = 0;
      tick();
      chk("stall_state_wait", 64'(o_state), 64'd2);
      tick();
      cont[1] = 1;
      tick();
      chk("stall_cnt_pre", 64'(o_stall), 64'd3);
      chk("stall_done_pre", 64'(o_done), 64'd0);
      tick();
      chk("stall_cnt", 64'(o_stall), 64'd3);
      chk("stall_done", 64'(o_done), 64'd1);
      chk("stall_state_idle", 64'(o_state), 64'd0);

      // one-cycle transaction on ch0
      rd_sel = 1'b0;
      start[0] = 1; ready[0] = 1; done[0] = 1;
      tick();
      start[0] = 0; ready[0] = 0; done[0] = 0;
      tick();
      chk("onecyc_lat",   64'(o_last),  64'd1);
      chk("onecyc_start", 64'(o_start), 64'd2);
      chk("onecyc_done",  64'(o_done),  64'd2);
      chk("onecyc_state", 64'(o_state), 64'd0);

      // latencies 4, 9, 2
      txn(0, 4); txn(0, 9); txn(0, 2);
      tick();
      chk("maxlat_last", 64'(o_last), 64'd2);
`ifdef AP_STATUS_MONITOR_MAXLAT_EN
      chk("maxlat_max", 64'(o_max), 64'd9);
`else
      chk("maxlat_off", 64'(o_max), 64'd0);
`endif

      // random traffic
      repeat (1500) begin
         for (int c = 0; c < NCH; c++) begin
            start[c] = 1'($urandom);
            ready[c] = 1'($urandom);
            done[c]  = ($urandom_range(3) == 0);
            cont[c]  = ($urandom_range(2) != 0);
         end
         finish = ($urandom_range(19) == 0);
         clear  = ($urandom_range(199) == 0);
         rd_sel = 1'($urandom);
         tick();
      end
      start = '0; ready = '0; done = '0; cont = '1; finish = 0; clear = 0;
      rd_sel = 1'b0;

      // freeze while BUSY, then clear, then reset mid-BUSY
      clear = 1;
      tick();
      clear = 0;
      start[0] = 1; ready[0] = 1;
      tick();
      start[0] = 0; ready[0] = 0;
      tick(); tick();
      finish = 1;
      repeat (10) begin
         done[0] = 1; start[1] = 1; ready[1] = 1; rd_sel = ~rd_sel;
         tick();
         chk("frozen_state", 64'(o_state), 64'd1);
         chk("frozen_start", 64'(o_start), 64'd1);
      end
      finish = 0; done = '0; start = '0; ready = '0; rd_sel = 1'b0;
      clear = 1;
      tick();
      chk("clear_start", 64'(o_start), 64'd0);
      clear = 0;
      tick();
      chk("clear_state", 64'(o_state), 64'd0);
      chk("clear_ch1_untouched", 64'(m_start[1]), 64'd0);
      start[0] = 1; ready[0] = 1;
      tick();
      start[0] = 0; ready[0] = 0;
      tick();
      chk("pre_reset_busy", 64'(o_state), 64'd1);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk); #1;
      check_all();
      rst_n = 1'b1;
      done[0] = 1;
      tick();
      done[0] = 0;
      tick();
      chk("post_reset_start", 64'(o_start), 64'd0);
      chk("post_reset_done",  64'(o_done),  64'd0);
      chk("post_reset_state", 64'(o_state), 64'd0);

      // saturation: 300 one-cycle transactions
      start[0] = 1; ready[0] = 1; done[0] = 1; cont[0] = 1;
      repeat (300) tick();
      start = '0; ready = '0; done = '0;
      tick();
      chk("sat_start", 64'(o_start), 64'd255);
      chk("sat_done",  64'(o_done),  64'd255);
      chk("sat_ovf",   64'(o_ovf),   64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
